// File: rtl/scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } scan_state_t;

    // Width needed to hold the larger of the two window lengths.
    function automatic int cnt_width(input int prescale, input int blank);
        int m;
        m = (prescale > blank) ? prescale : blank;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter timing the ACTIVE and BLANK windows; flags terminal count.
module slot_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // Count register: load wins, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Drives enable E and address A for the select decoder, with dead cycles so A
// only moves while E is low.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int ADDR_W   = 1,
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    output logic              E,
    output logic [ADDR_W-1:0] A,
    output logic              slot_done,
    output logic              frame_done
);

    localparam int CW = cnt_width(PRESCALE, BLANK);
    localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};

    if (PRESCALE < 1) begin : g_chk_prescale
        $fatal(1, "scan_sequencer: PRESCALE must be >= 1");
    end
    if (BLANK < 1) begin : g_chk_blank
        $fatal(1, "scan_sequencer: BLANK must be >= 1");
    end

    scan_state_t       r_state;
    scan_state_t       w_next;
    logic              r_step_mode;
    logic              w_step_mode_next;
    logic              r_e;
    logic [ADDR_W-1:0] r_a;
    logic              r_slot_done;
    logic              r_frame_done;
    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_tc;
    logic              w_adv;

    slot_timer #(
        .CW (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (r_state != S_IDLE),
        .o_tc       (w_tc)
    );

    // Next-state logic; the timer is reloaded on every entry to ACTIVE or BLANK.
    always_comb begin
        w_next           = r_state;
        w_step_mode_next = r_step_mode;
        w_load           = 1'b0;
        w_load_val       = '0;
        w_adv            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next           = S_ACTIVE;
                    w_step_mode_next = 1'b0;
                    w_load           = 1'b1;
                    w_load_val       = CW'(PRESCALE - 1);
                end else if (step) begin
                    w_next           = S_ACTIVE;
                    w_step_mode_next = 1'b1;
                    w_load           = 1'b1;
                    w_load_val       = CW'(PRESCALE - 1);
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (w_tc) begin
                    w_next     = S_BLANK;
                    w_load     = 1'b1;
                    w_load_val = CW'(BLANK - 1);
                end else begin
                    w_next = S_ACTIVE;
                end
            end
            S_BLANK: begin
                if (w_tc) begin
                    w_adv            = 1'b1;
                    w_step_mode_next = 1'b0;
                    if (run && !r_step_mode) begin
                        w_next     = S_ACTIVE;
                        w_load     = 1'b1;
                        w_load_val = CW'(PRESCALE - 1);
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_next = S_BLANK;
                end
            end
            default: begin
                w_next           = S_IDLE;
                w_step_mode_next = 1'b0;
            end
        endcase
    end

    // State and output registers; E follows the next state so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_step_mode  <= 1'b0;
            r_e          <= 1'b0;
            r_a          <= '0;
            r_slot_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_step_mode  <= w_step_mode_next;
            r_e          <= (w_next == S_ACTIVE);
            r_slot_done  <= (r_state == S_ACTIVE) && w_tc;
            r_frame_done <= w_adv && (r_a == A_MAX);
            if (w_adv) begin
                r_a <= r_a + ADDR_W'(1);
            end else begin
                r_a <= r_a;
            end
        end
    end

    assign E          = r_e;
    assign A          = r_a;
    assign slot_done  = r_slot_done;
    assign frame_done = r_frame_done;

endmodule
